cnn_row_feeder: RTL

- Front-end stage directly upstream of the CNN pipeline's first 3-line buffer.
- Accepts a raster pixel stream, one byte per beat, with valid/ready.
- Packs W pixels into one row word and queues rows in a small FIFO.
- Issues rows to the first line buffer as single-cycle row_valid_o pulses, paced by a programmable inter-row gap; also marks frame boundaries.

---
 rtl/cnn_row_feeder.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/cnn_row_feeder.sv
// Packs a raster pixel stream into W-pixel rows, queues them in a small FIFO and issues
// paced single-cycle row pulses; `CNN_ROW_FEEDER_FRAME_SYNC_EN adds a frame_ack_i hold-off after each frame.
module cnn_row_feeder #(
  parameter int W          = 24,
  parameter int H          = 24,
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int ROW_GAP    = 30
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [DATA_WIDTH-1:0]         pix_i,
  input  logic                          pix_valid_i,
  output logic                          pix_ready_o,
  output logic [W*DATA_WIDTH-1:0]       row_data_o,
  output logic                          row_valid_o,
  output logic                          frame_start_o,
  output logic                          frame_done_o,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level_o
`ifdef CNN_ROW_FEEDER_FRAME_SYNC_EN
  ,
  input  logic                          frame_ack_i
`endif
);

  localparam int RW = W * DATA_WIDTH;
  localparam int CW = (W > 1) ? $clog2(W) : 1;
  localparam int HW = (H > 1) ? $clog2(H) : 1;
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int LW = $clog2(FIFO_DEPTH) + 1;
  localparam int GW = $clog2(ROW_GAP + 1);

  localparam logic [CW-1:0] COL_LAST = CW'(W - 1);
  localparam logic [HW-1:0] ROW_LAST = HW'(H - 1);
  localparam logic [GW-1:0] GAP_LOAD = GW'(ROW_GAP - 1);
  localparam logic [LW-1:0] LVL_FULL = LW'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, EMIT, GAP, WAIT_ACK} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   col_q, col_d;
  logic [HW-1:0]   row_cnt_q, row_cnt_d;
  logic [GW-1:0]   gap_q, gap_d;
  logic [RW-1:0]   row_buf_q, row_buf_d;
  logic [RW-1:0]   row_data_q, row_data_d;
  logic            row_valid_q, row_valid_d;
  logic            frame_start_q, frame_start_d;
  logic            frame_done_q, frame_done_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]   level_q, level_d;
  logic [RW-1:0]   mem_q [FIFO_DEPTH];

  logic accept;
  logic push;
  logic pop;

  always_comb begin
    pix_ready_o = (level_q != LVL_FULL);
    accept      = pix_valid_i && pix_ready_o;
    push        = 1'b0;
    col_d       = col_q;
    row_buf_d   = row_buf_q;
    // The completing pixel is merged here so the full row is pushed in the same cycle.
    if (accept) begin
      row_buf_d[(W - int'(col_q)) * DATA_WIDTH - 1 -: DATA_WIDTH] = pix_i;
      if (col_q == COL_LAST) begin
        col_d = '0;
        push  = 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
    end

    pop           = 1'b0;
    state_d       = state_q;
    gap_d         = gap_q;
    row_cnt_d     = row_cnt_q;
    row_data_d    = row_data_q;
    row_valid_d   = 1'b0;
    frame_start_d = 1'b0;
    frame_done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (level_q != '0) begin
          pop           = 1'b1;
          row_data_d    = mem_q[rd_ptr_q];
          row_valid_d   = 1'b1;
          frame_start_d = (row_cnt_q == '0);
          frame_done_d  = (row_cnt_q == ROW_LAST);
          state_d       = EMIT;
        end
      end
      EMIT: begin
        row_cnt_d = (row_cnt_q == ROW_LAST) ? '0 : row_cnt_q + 1'b1;
        gap_d     = GAP_LOAD;
        state_d   = (ROW_GAP == 1) ? IDLE : GAP;
`ifdef CNN_ROW_FEEDER_FRAME_SYNC_EN
        if (row_cnt_q == ROW_LAST) state_d = WAIT_ACK;
`endif
      end
      GAP: begin
        gap_d = gap_q - 1'b1;
        if (gap_q <= GW'(1)) state_d = IDLE;
      end
      WAIT_ACK: begin
`ifdef CNN_ROW_FEEDER_FRAME_SYNC_EN
        if (frame_ack_i) state_d = IDLE;
`else
        state_d = IDLE;
`endif
      end
      default: state_d = IDLE;
    endcase

    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    level_d  = level_q + LW'(push) - LW'(pop);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      col_q         <= '0;
      row_cnt_q     <= '0;
      gap_q         <= '0;
      row_buf_q     <= '0;
      row_data_q    <= '0;
      row_valid_q   <= 1'b0;
      frame_start_q <= 1'b0;
      frame_done_q  <= 1'b0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      level_q       <= '0;
    end else begin
      state_q       <= state_d;
      col_q         <= col_d;
      row_cnt_q     <= row_cnt_d;
      gap_q         <= gap_d;
      row_buf_q     <= row_buf_d;
      row_data_q    <= row_data_d;
      row_valid_q   <= row_valid_d;
      frame_start_q <= frame_start_d;
      frame_done_q  <= frame_done_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      level_q       <= level_d;
    end
  end

  // Row storage carries no reset; occupancy is tracked solely by the pointers and level.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= row_buf_d;
  end

  assign row_data_o    = row_data_q;
  assign row_valid_o   = row_valid_q;
  assign frame_start_o = frame_start_q;
  assign frame_done_o  = frame_done_q;
  assign fifo_level_o  = level_q;

endmodule
